// File: rtl/trace_buffer_pkg.sv
// Shared types and default sizing for the trace capture buffer.
package trace_buffer_pkg;

  localparam int unsigned TB_N          = 8;
  localparam int unsigned TB_DATA_WIDTH = 32;
  localparam int unsigned TB_DEPTH      = 16;

  typedef enum logic {CAPTURE, DRAIN} tb_state_t;

  typedef logic [TB_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [TB_N-1:0]         vector_t;

endpackage

// File: rtl/trace_buffer_if.sv
// Capture/readout bundle of the trace buffer; i_/o_ names are from the buffer's point of view.
interface trace_buffer_if #(
  parameter int unsigned N          = trace_buffer_pkg::TB_N,
  parameter int unsigned DATA_WIDTH = trace_buffer_pkg::TB_DATA_WIDTH,
  parameter int unsigned DEPTH      = trace_buffer_pkg::TB_DEPTH
);

  logic                         i_tracing;
  logic                         i_valid_in;
  logic [N-1:0][DATA_WIDTH-1:0] i_vector_in;
  logic                         i_drain_req;
  logic                         i_rd_ready;
  logic [N-1:0][DATA_WIDTH-1:0] o_vector_out;
  logic                         o_rd_valid;
  logic                         o_rd_last;
  logic [$clog2(DEPTH):0]       o_entries;
  logic                         o_overflowed;
  logic                         o_dropped;
  logic                         o_busy;

  modport master (
    output i_tracing, i_valid_in, i_vector_in, i_drain_req, i_rd_ready,
    input  o_vector_out, o_rd_valid, o_rd_last, o_entries, o_overflowed, o_dropped, o_busy
  );

  modport slave (
    input  i_tracing, i_valid_in, i_vector_in, i_drain_req, i_rd_ready,
    output o_vector_out, o_rd_valid, o_rd_last, o_entries, o_overflowed, o_dropped, o_busy
  );

endinterface

// File: rtl/tb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port; no reset so it maps to block RAM.
module tb_sdp_ram #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_buffer.sv
// Circular capture of packed vectors while tracing; oldest-first drain over a valid/ready port.
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int unsigned N          = TB_N,
  parameter int unsigned DATA_WIDTH = TB_DATA_WIDTH,
  parameter int unsigned DEPTH      = TB_DEPTH
) (
  input logic           clk,
  input logic           rst,
  trace_buffer_if.slave bus
);

  localparam int unsigned VecW = N * DATA_WIDTH;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = PtrW + 1;

  tb_state_t       r_state, w_state_next;
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, r_fetch_ptr;
  logic [EntW-1:0] r_entries, r_fetch_left;
  logic            r_overflowed, r_dropped;
  logic            r_ram_vld, r_ram_last;
  logic            r_skid_vld, r_skid_last;
  logic            r_out_vld, r_out_last;
  logic [VecW-1:0] r_skid_data, r_out_data, w_ram_rdata;
  logic            w_full, w_write, w_start, w_xfer, w_done, w_issue, w_busy;
  logic [1:0]      w_occ;

  always_comb begin
    w_full  = (r_entries == EntW'(DEPTH));
    w_write = (r_state == CAPTURE) && bus.i_valid_in && bus.i_tracing;
    w_start = (r_state == CAPTURE) && bus.i_drain_req && !bus.i_tracing && (r_entries != '0);
    w_xfer  = r_out_vld && bus.i_rd_ready;
    w_done  = w_xfer && r_out_last;
    // Only fetch when the read in flight is guaranteed a slot in output or skid register.
    w_occ   = 2'(r_ram_vld) + 2'(r_skid_vld) + 2'(r_out_vld);
    w_issue = (r_state == DRAIN) && (r_fetch_left != '0) &&
              ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_xfer));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CAPTURE: if (w_start) w_state_next = DRAIN;
      DRAIN:   if (w_done)  w_state_next = CAPTURE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fetch_ptr  <= '0;
      r_entries    <= '0;
      r_fetch_left <= '0;
      r_overflowed <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_full) begin
          r_rd_ptr     <= r_rd_ptr + PtrW'(1);
          r_overflowed <= 1'b1;
        end else begin
          r_entries <= r_entries + EntW'(1);
        end
      end
      if (w_start) begin
        r_fetch_ptr  <= r_rd_ptr;
        r_fetch_left <= r_entries;
      end
      if (w_issue) begin
        r_fetch_ptr  <= r_fetch_ptr + PtrW'(1);
        r_fetch_left <= r_fetch_left - EntW'(1);
      end
      if (w_busy && bus.i_valid_in && bus.i_tracing) r_dropped <= 1'b1;
      if (w_xfer) begin
        r_rd_ptr  <= r_rd_ptr + PtrW'(1);
        r_entries <= r_entries - EntW'(1);
      end
      if (w_done) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_overflowed <= 1'b0;
        r_dropped    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_vld   <= 1'b0;
      r_ram_last  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_ram_vld <= w_issue;
      if (w_issue) r_ram_last <= (r_fetch_left == EntW'(1));
      if (!r_out_vld || w_xfer) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_last  <= r_skid_last;
          r_skid_vld  <= r_ram_vld;
          r_skid_data <= w_ram_rdata;
          r_skid_last <= r_ram_last;
        end else if (r_ram_vld) begin
          r_out_vld  <= 1'b1;
          r_out_data <= w_ram_rdata;
          r_out_last <= r_ram_last;
        end else begin
          r_out_vld <= 1'b0;
        end
      end else if (r_ram_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_ram_rdata;
        r_skid_last <= r_ram_last;
      end
    end
  end

  tb_sdp_ram #(
    .Width(VecW),
    .Depth(DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.i_vector_in),
    .i_re    (w_issue),
    .i_raddr (r_fetch_ptr),
    .o_rdata (w_ram_rdata)
  );

  assign bus.o_vector_out = r_out_data;
  assign bus.o_rd_valid   = r_out_vld;
  assign bus.o_rd_last    = r_out_vld && r_out_last;
  assign bus.o_entries    = r_entries;
  assign bus.o_overflowed = r_overflowed;
  assign bus.o_dropped    = r_dropped;
  assign bus.o_busy       = w_busy;

endmodule
